adc_scan: RTL and testbench
===========================

Name: adc_scan

Overview:
- SPI master for the front-panel 8-channel, 8-bit serial ADC that digitises the analog selector switches.
- Continuously round-robins channels 0..NUM_CH-1.
- Delivers each 8-bit result with its channel number and a one-cycle valid strobe.
- Results feed the sw6 position decoders and other panel-control consumers. Sits between the ADC pins and all panel decoders.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (>=2).
- NUM_CH, 8, channels scanned, 1..8; channels 0..NUM_CH-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  run scanning while high
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  serial clock, idles high
- adc_din  out  1  address bits to ADC
- adc_dout  in  1  conversion data from ADC; synchronised internally with 2 flops
- sample  out  8  last result, MSB = DB7
- sample_ch  out  3  channel of sample
- sample_valid  out  1  one-clk pulse when sample/sample_ch update

Behaviour:
- Reset: the async assert forces these values immediately.
  - adc_cs_n=1, adc_sclk=1, adc_din=0.
  - sample=0, sample_ch=0, sample_valid=0.
  - State IDLE; channel counter 0; first-frame flag set.
- Tick: a half-period tick fires every CLK_DIV clks while not IDLE. All SCLK/CS transitions occur on ticks.
- States:
  - IDLE: all pins at reset values. When enable=1, go to SETUP and set the first-frame flag.
  - SETUP: adc_cs_n=0, adc_sclk=1 for one half-period. Then go to SHIFT.
  - SHIFT: 16 SCLK cycles (32 half-periods), each falling half then rising half. Rising edges are numbered 0..15.
  - HOLD: adc_cs_n=1, adc_sclk=1 for one half-period. Then go to SETUP if enable=1, else IDLE.
- Frame period: 34*CLK_DIV clks (136 at default).
- DIN: changes only on SCLK falling edges.
  - Stable across rising edges 2, 3, 4, carrying ADD2, ADD1, ADD0 of next_ch.
  - Otherwise 0.
- DOUT: sampled (post-synchroniser, compensated so the sample aligns to the SCLK rising instant) on rising edges 4..11 = DB7..DB0.
  - Other bits are ignored.
- Pipelining: the ADC converts the address sent in the previous frame.
  - The block keeps sent_ch (address sent in the current frame) and conv_ch (channel being returned).
  - At each frame end: conv_ch <= sent_ch.
- First frame after leaving IDLE:
  - Sends address 0.
  - Result is discarded (no sample_valid), because the ADC address is unknown.
- Subsequent frames:
  - Send (previous sent_ch + 1), wrapping NUM_CH-1 -> 0.
  - NUM_CH=1 always sends 0.
- Result update:
  - In the clk where adc_cs_n rises (entry to HOLD), sample <= shifted byte and sample_ch <= conv_ch.
  - sample_valid=1 for exactly that clk; otherwise 0.
  - sample/sample_ch hold between updates.
- Output sequence after start: results for ch 0,1,...,NUM_CH-1,0,...; the first valid arrives at the end of frame 2.
- Enable dropped mid-frame: the current frame completes, including its valid if any, then IDLE. Re-enable restarts with the discard frame and ch 0.
- Enable pulse shorter than a frame while in IDLE: one discard frame runs, then IDLE.
- Reset mid-frame: pins return to idle immediately. No valid emitted and no partial sample update.
- All outputs are registered; no combinational path from adc_dout to outputs.

Decomposition:
- Shared package adc_pkg holds constants only:
  - ADC_FRAME_BITS=16, ADC_ADDR_FIRST_EDGE=2, ADC_ADDR_BITS=3, ADC_DATA_FIRST_EDGE=4, ADC_DATA_BITS=8.
  - Typedef adc_ch_t = 3-bit channel.
- One sub-module, adc_sclk_div: CLK_DIV half-period tick counter with sync clear, reset to 0.
- FSM, shift registers and channel pipeline live in adc_scan.

Test Plan:
- Reset mid-SHIFT (CLK_DIV=4, NUM_CH=8) -> cs_n=1, sclk=1, din=0, sample=0, valid=0 in the same cycle rst asserts.
- ADC model returns 8'h10*ch+ch for the address latched in the previous frame; enable held -> valids in order ch0..7,0 with samples 00,11,...,77,00; first frame yields no valid; valid spacing 136 clks.
- Check DIN with the model -> addresses 0,1,2,...,7,0 appear MSB-first on rising edges 2-4; DIN=0 elsewhere; DIN never changes while sclk is high.
- Model drives DOUT=A5 on data edges and 1s on all other bits -> sample=8'hA5 exactly (non-data bits ignored).
- Drop enable at rising edge 7 of a frame -> frame finishes, its valid is emitted, HOLD then IDLE; re-enable -> discard frame with address 0, next valid has sample_ch=0.
- NUM_CH=3 -> sample_ch sequence 0,1,2,0,1; CLK_DIV=2 -> frame period 68 clks.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: constants shared by the front-panel ADC scanner.
//   Frame layout of the 8-channel serial ADC: 16 SCLK cycles per frame.
//   The address is taken on rising edges 2..4 and data is returned on
//   rising edges 4..11, MSB first.
package adc_pkg;

  localparam int ADC_FRAME_BITS      = 16;
  localparam int ADC_ADDR_FIRST_EDGE = 2;
  localparam int ADC_ADDR_BITS       = 3;
  localparam int ADC_DATA_FIRST_EDGE = 4;
  localparam int ADC_DATA_BITS       = 8;

  typedef logic [2:0] adc_ch_t;

endpackage

// File: rtl/adc_sclk_div.sv
// adc_sclk_div: SCLK half-period tick generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset (counter to 0)
//   clr  : synchronous clear; holds the counter at 0 and suppresses tick
//   tick : one-clk pulse every CLK_DIV clks while clr is low
module adc_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_scan.sv
// adc_scan: SPI master that round-robins the front-panel serial ADC over
// channels 0..NUM_CH-1 and delivers each 8-bit result with its channel.
//   clk, rst      : system clock, asynchronous active-high reset
//   enable        : keep scanning while high
//   adc_cs_n      : chip select, active low
//   adc_sclk      : serial clock, idles high
//   adc_din       : address bits to the ADC (changes on SCLK falling edges)
//   adc_dout      : data from the ADC (asynchronous, double-synchronised)
//   sample        : last result, MSB = DB7
//   sample_ch     : channel of sample
//   sample_valid  : one-clk pulse when sample/sample_ch update
//
// state | meaning
// IDLE  | pins idle, divider held clear, waiting for enable
// SETUP | CS low, SCLK high for one half-period
// SHIFT | 16 SCLK cycles, half_q counts 32 half-periods (even = SCLK low)
// HOLD  | CS high for one half-period; result published on entry
module adc_scan
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_CH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [7:0] sample,
  output logic [2:0] sample_ch,
  output logic       sample_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  localparam logic [4:0] LAST_HALF = 5'(2 * ADC_FRAME_BITS - 1);
  localparam logic [3:0] ADDR_LO   = 4'(ADC_ADDR_FIRST_EDGE);
  localparam logic [3:0] ADDR_HI   = 4'(ADC_ADDR_FIRST_EDGE + ADC_ADDR_BITS - 1);
  localparam logic [3:0] DATA_LO   = 4'(ADC_DATA_FIRST_EDGE);
  localparam logic [3:0] DATA_HI   = 4'(ADC_DATA_FIRST_EDGE + ADC_DATA_BITS - 1);
  localparam adc_ch_t    LAST_CH   = adc_ch_t'(NUM_CH - 1);

  state_t     state_q, state_d;
  logic [4:0] half_q, half_d;
  adc_ch_t    sent_ch_q, sent_ch_d;
  adc_ch_t    conv_ch_q, conv_ch_d;
  logic       first_q, first_d;
  logic [1:0] sync_q;
  logic [1:0] cap_q, cap_d;
  logic [7:0] shift_q, shift_d;
  logic       cs_n_q, cs_n_d;
  logic       sclk_q, sclk_d;
  logic       din_q, din_d;
  logic [7:0] sample_q, sample_d;
  adc_ch_t    sample_ch_q, sample_ch_d;
  logic       sample_valid_q, sample_valid_d;
  logic       tick;
  logic [3:0] rise_edge;
  logic [3:0] next_edge;

  adc_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == S_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d        = state_q;
    half_d         = half_q;
    sent_ch_d      = sent_ch_q;
    conv_ch_d      = conv_ch_q;
    first_d        = first_q;
    sample_d       = sample_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    shift_d        = shift_q;
    rise_edge      = half_q[4:1];
    // The capture strobe trails the SCLK rising tick by two clks so that it
    // lines up with the pin value seen at that instant after the synchroniser.
    cap_d          = {cap_q[0], 1'b0};

    if (cap_q[1]) shift_d = {shift_q[6:0], sync_q[1]};

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_SETUP;
          first_d   = 1'b1;
          sent_ch_d = '0;
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
          half_d  = '0;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!half_q[0] && rise_edge >= DATA_LO && rise_edge <= DATA_HI)
            cap_d[0] = 1'b1;
          if (half_q == LAST_HALF) begin
            state_d        = S_HOLD;
            sample_d       = shift_q;
            sample_ch_d    = conv_ch_q;
            sample_valid_d = !first_q;
            conv_ch_d      = sent_ch_q;
            first_d        = 1'b0;
          end else begin
            half_d = half_q + 5'd1;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          if (enable) begin
            state_d   = S_SETUP;
            sent_ch_d = (sent_ch_q == LAST_CH) ? '0 : sent_ch_q + 3'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the next state so every edge lands on a tick.
    next_edge = half_d[4:1];
    cs_n_d    = !(state_d == S_SETUP || state_d == S_SHIFT);
    sclk_d    = (state_d == S_SHIFT) ? half_d[0] : 1'b1;
    din_d     = 1'b0;
    if (state_d == S_SHIFT && next_edge >= ADDR_LO && next_edge <= ADDR_HI)
      din_d = sent_ch_d[2'(ADDR_HI - next_edge)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      half_q         <= '0;
      sent_ch_q      <= '0;
      conv_ch_q      <= '0;
      first_q        <= 1'b1;
      sync_q         <= '0;
      cap_q          <= '0;
      shift_q        <= '0;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b1;
      din_q          <= 1'b0;
      sample_q       <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      half_q         <= half_d;
      sent_ch_q      <= sent_ch_d;
      conv_ch_q      <= conv_ch_d;
      first_q        <= first_d;
      sync_q         <= {sync_q[0], adc_dout};
      cap_q          <= cap_d;
      shift_q        <= shift_d;
      cs_n_q         <= cs_n_d;
      sclk_q         <= sclk_d;
      din_q          <= din_d;
      sample_q       <= sample_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_adc_scan.sv
module tb_adc_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cs0, sclk0, din0, v0;
  logic       dout0 = 1'b1;
  logic [7:0] smp0;
  logic [2:0] ch0;
  logic       cs1, sclk1, din1, v1;
  logic       dout1 = 1'b1;
  logic [7:0] smp1;
  logic [2:0] ch1;

  adc_scan #(.CLK_DIV(4), .NUM_CH(8)) dut (
    .clk(clk), .rst(rst), .enable(en0), .adc_cs_n(cs0), .adc_sclk(sclk0),
    .adc_din(din0), .adc_dout(dout0), .sample(smp0), .sample_ch(ch0),
    .sample_valid(v0));

  adc_scan #(.CLK_DIV(2), .NUM_CH(3)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .adc_cs_n(cs1), .adc_sclk(sclk1),
    .adc_din(din1), .adc_dout(dout1), .sample(smp1), .sample_ch(ch1),
    .sample_valid(v1));

  typedef struct {
    logic [7:0] s;
    logic [2:0] c;
    int         t;
    bit         cs_rise;
  } vrec_t;

  vrec_t      vq0[$];
  vrec_t      vq1[$];
  int         addr_q0[$];
  int         addr_q1[$];
  int         mode0 = 0;
  logic [7:0] tab [8];
  int         din_bad0 = 0;
  int         din_hi0  = 0;
  int         rise0 = 0;
  int         rise1 = 0;
  logic [2:0] addr0 = '0, prev0 = '0, addr1 = '0, prev1 = '0;
  logic       pcs0 = 1'b1, psclk0 = 1'b1, pdin0 = 1'b0;
  logic       pcs1 = 1'b1, psclk1 = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Word the ADC returns for a converted channel.
  function automatic logic [7:0] adc_word(int mode, logic [2:0] ch);
    if (mode == 1) return 8'hA5;
    if (mode == 2) return tab[ch];
    return 8'(16 * int'(ch) + int'(ch));
  endfunction

  // ADC model for dut: latches the 3 address bits on rising edges 2..4,
  // returns the word for the previous frame's address on edges 4..11
  // (driven after falling edges), 1s elsewhere.
  always @(negedge clk) begin : model0
    logic [7:0] w;
    if (!rst) begin
      if (v0 === 1'b1) vq0.push_back('{smp0, ch0, cyc, (!pcs0 && cs0)});
      if (pcs0 && !cs0) begin rise0 = 0; addr0 = '0; end
      if (!cs0 && psclk0 && !sclk0) begin
        w = adc_word(mode0, prev0);
        dout0 = (rise0 >= 4 && rise0 < 12) ? w[3'(11 - rise0)] : 1'b1;
      end
      if (!cs0 && !psclk0 && sclk0) begin
        if (rise0 >= 2 && rise0 <= 4) addr0[2'(4 - rise0)] = din0;
        else if (din0 !== 1'b0) din_bad0++;
        rise0++;
      end
      if (!cs0 && psclk0 && sclk0 && din0 !== pdin0) din_hi0++;
      if (!pcs0 && cs0 && rise0 == 16) begin
        addr_q0.push_back(int'(addr0));
        prev0 = addr0;
      end
    end
    pcs0 = cs0; psclk0 = sclk0; pdin0 = din0;
  end

  always @(negedge clk) begin : model1
    logic [7:0] w;
    if (!rst) begin
      if (v1 === 1'b1) vq1.push_back('{smp1, ch1, cyc, (!pcs1 && cs1)});
      if (pcs1 && !cs1) begin rise1 = 0; addr1 = '0; end
      if (!cs1 && psclk1 && !sclk1) begin
        w = adc_word(0, prev1);
        dout1 = (rise1 >= 4 && rise1 < 12) ? w[3'(11 - rise1)] : 1'b1;
      end
      if (!cs1 && !psclk1 && sclk1) begin
        if (rise1 >= 2 && rise1 <= 4) addr1[2'(4 - rise1)] = din1;
        rise1++;
      end
      if (!pcs1 && cs1 && rise1 == 16) begin
        addr_q1.push_back(int'(addr1));
        prev1 = addr1;
      end
    end
    pcs1 = cs1; psclk1 = sclk1;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_v0(int n, int budget);
    int k = 0;
    while (vq0.size() < n && k < budget) begin @(posedge clk); k++; end
    chk("valid0_wait", (vq0.size() >= n) ? 1 : 0, 1);
  endtask

  function automatic vrec_t pop0();
    vrec_t r;
    r = '{8'hxx, 3'bxxx, -1, 1'b0};
    if (vq0.size() > 0) r = vq0.pop_front();
    return r;
  endfunction

  function automatic vrec_t pop1();
    vrec_t r;
    r = '{8'hxx, 3'bxxx, -1, 1'b0};
    if (vq1.size() > 0) r = vq1.pop_front();
    return r;
  endfunction

  initial begin
    vrec_t r;
    int    t_en, t_prev, lastc, k, exp_c;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", cs0, 1);
    chk("rst_sclk", sclk0, 1);
    chk("rst_din", din0, 0);
    chk("rst_sample", smp0, 0);
    chk("rst_sample_ch", ch0, 0);
    chk("rst_valid", v0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    en0 = 1'b1; en1 = 1'b1;
    t_en = cyc;

    // Continuous scan: results ch0..7,0 with 16*ch+ch, first at end of frame 2.
    wait_v0(9, 11 * 136);
    t_prev = 0;
    for (int i = 0; i < 9; i++) begin
      r = pop0();
      chk("scan_ch", r.c, i % 8);
      chk("scan_sample", r.s, 17 * (i % 8));
      chk("scan_cs_rise", r.cs_rise, 1);
      if (i == 0) chk("scan_first_time", r.t, t_en + 1 + 67 * 4);
      else        chk("scan_period", r.t - t_prev, 136);
      t_prev = r.t;
    end
    chk("addr_count", (addr_q0.size() >= 9) ? 1 : 0, 1);
    for (int i = 0; i < 9 && i < addr_q0.size(); i++) chk("din_addr", addr_q0[i], i % 8);
    chk("din_zero_elsewhere", din_bad0, 0);
    chk("din_stable_sclk_high", din_hi0, 0);

    // NUM_CH=3, CLK_DIV=2 instance.
    chk("n3_count", (vq1.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      r = pop1();
      chk("n3_ch", r.c, i % 3);
      chk("n3_sample", r.s, 17 * (i % 3));
      if (i == 0) chk("n3_first_time", r.t, t_en + 1 + 67 * 2);
      else        chk("n3_period", r.t - t_prev, 68);
      t_prev = r.t;
    end

    // Non-data bits are all 1s; only edges 4..11 may reach sample.
    mode0 = 1;
    vq0.delete();
    wait_v0(2, 3 * 136);
    for (int i = 0; i < 2; i++) begin
      r = pop0();
      chk("a5_sample", r.s, 8'hA5);
    end

    // Random per-channel data.
    foreach (tab[i]) tab[i] = 8'($urandom);
    mode0 = 2;
    vq0.delete();
    wait_v0(8, 9 * 136);
    lastc = 0;
    for (int i = 0; i < 8; i++) begin
      r = pop0();
      chk("rand_sample", r.s, tab[r.c]);
      if (i > 0) chk("rand_ch_seq", r.c, (lastc + 1) % 8);
      lastc = int'(r.c);
    end

    // Drop enable at rising edge 7: frame finishes with its valid, then idle.
    k = 0;
    while (!(rise0 == 8 && cs0 === 1'b0) && k < 400) begin @(negedge clk); k++; end
    chk("drop_reach_edge7", (k < 400) ? 1 : 0, 1);
    en0 = 1'b0;
    vq0.delete();
    wait_v0(1, 300);
    r = pop0();
    exp_c = (lastc + 1) % 8;
    chk("drop_valid_ch", r.c, exp_c);
    chk("drop_valid_sample", r.s, tab[exp_c]);
    addr_q0.delete();
    repeat (300) @(posedge clk); #1;
    chk("idle_no_valid", vq0.size(), 0);
    chk("idle_no_frame", addr_q0.size(), 0);
    chk("idle_cs_n", cs0, 1);
    chk("idle_sclk", sclk0, 1);

    // Re-enable: discard frame with address 0, then ch0 result.
    @(posedge clk); #1;
    en0 = 1'b1;
    t_en = cyc;
    wait_v0(1, 3 * 136);
    r = pop0();
    chk("reen_ch", r.c, 0);
    chk("reen_sample", r.s, tab[0]);
    chk("reen_time", r.t, t_en + 1 + 67 * 4);
    chk("reen_addr0", (addr_q0.size() > 0) ? addr_q0[0] : -1, 0);
    chk("reen_addr1", (addr_q0.size() > 1) ? addr_q0[1] : -1, 1);

    // Reset in the high half of rising edge 3 of the frame sending address 2.
    k = 0;
    while (!(rise0 == 4 && sclk0 === 1'b1 && cs0 === 1'b0) && k < 400) begin
      @(negedge clk); k++;
    end
    chk("pre_rst_reach", (k < 400) ? 1 : 0, 1);
    chk("pre_rst_din_add1", din0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", cs0, 1);
    chk("mid_rst_sclk", sclk0, 1);
    chk("mid_rst_din", din0, 0);
    chk("mid_rst_sample", smp0, 0);
    chk("mid_rst_valid", v0, 0);

    // Short enable pulse on the NUM_CH=3 instance: one discard frame only.
    en1 = 1'b0;
    vq0.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    vq1.delete();
    addr_q1.delete();
    @(posedge clk); #1;
    en1 = 1'b1;
    repeat (5) @(posedge clk); #1;
    en1 = 1'b0;
    repeat (200) @(posedge clk); #1;
    chk("pulse_frames", addr_q1.size(), 1);
    chk("pulse_addr", (addr_q1.size() > 0) ? addr_q1[0] : -1, 0);
    chk("pulse_no_valid", vq1.size(), 0);
    chk("pulse_idle_cs_n", cs1, 1);
    chk("post_rst_no_valid", vq0.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
